// File: rtl/bittime_cfgctrl.sv
// Bit-timing configuration controller: quantum prescaler plus a checked, boundary-synchronised
// update of the active tseg1/tseg2/sjw/prescale set. Optional WAIT timeout: BTCFG_TIMEOUT_EN.
module bittime_cfgctrl #(
    parameter logic [7:0] DEF_PRESC  = 8'd1,
    parameter logic [3:0] DEF_TSEG1  = 4'd7,
    parameter logic [2:0] DEF_TSEG2  = 3'd3,
    parameter logic [1:0] DEF_SJW    = 2'd1
`ifdef BTCFG_TIMEOUT_EN
   ,parameter logic [9:0] TIMEOUT_TQ = 10'd1023
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cfg_wr,
    input  logic [7:0] cfg_presc,
    input  logic [3:0] cfg_tseg1,
    input  logic [2:0] cfg_tseg2,
    input  logic [1:0] cfg_sjw,
    input  logic       busidle,
    input  logic       sendpoint,
    output logic       Prescale_EN,
    output logic [3:0] tseg1,
    output logic [2:0] tseg2,
    output logic [1:0] sjw,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic [1:0] cfg_err,
    output logic       cfg_ovr,
    output logic [2:0] cfgst
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_APPLY  = 3'd3,
        ST_REJECT = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // A segment set is usable only if phase 2 exists, resync fits in it, and tseg1 covers tseg2.
    function automatic logic cfg_legal(input logic [3:0] t1, input logic [2:0] t2,
                                       input logic [1:0] s);
        return (t2 != 3'd0) && ({1'b0, s} <= t2) && (t1 >= {1'b0, t2});
    endfunction

    state_t     state_q, state_d;
    logic [1:0] err_q, err_d;
    logic       stage_en;
    logic       apply;
    logic       tmo;

    logic [7:0] presc_q;
    logic [3:0] tseg1_q;
    logic [2:0] tseg2_q;
    logic [1:0] sjw_q;

    logic [7:0] stg_presc_q;
    logic [3:0] stg_tseg1_q;
    logic [2:0] stg_tseg2_q;
    logic [1:0] stg_sjw_q;

    logic [7:0] pc_q, pc_d;
    logic       en_q, en_d;

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        stage_en = 1'b0;
        apply    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_wr) begin
                    stage_en = 1'b1;
                    err_d    = ERR_NONE;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (cfg_legal(stg_tseg1_q, stg_tseg2_q, stg_sjw_q)) begin
                    state_d = ST_WAIT;
                end else begin
                    err_d   = ERR_ILLEGAL;
                    state_d = ST_REJECT;
                end
            end
            ST_WAIT: begin
                // An idle bit boundary takes priority over a timeout landing on the same quantum.
                if (en_q && sendpoint && busidle) begin
                    state_d = ST_APPLY;
                end else if (tmo) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_REJECT;
                end
            end
            ST_APPLY: begin
                apply   = 1'b1;
                err_d   = ERR_NONE;
                state_d = ST_IDLE;
            end
            ST_REJECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Holding registers are only meaningful while a request is in flight, so no reset.
    always_ff @(posedge clock) begin
        if (stage_en) begin
            stg_presc_q <= cfg_presc;
            stg_tseg1_q <= cfg_tseg1;
            stg_tseg2_q <= cfg_tseg2;
            stg_sjw_q   <= cfg_sjw;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= DEF_PRESC;
            tseg1_q <= DEF_TSEG1;
            tseg2_q <= DEF_TSEG2;
            sjw_q   <= DEF_SJW;
        end else if (apply) begin
            presc_q <= stg_presc_q;
            tseg1_q <= stg_tseg1_q;
            tseg2_q <= stg_tseg2_q;
            sjw_q   <= stg_sjw_q;
        end
    end

    // Restarting the count on apply makes the first new quantum a full P_new+1 clocks long.
    always_comb begin
        pc_d = pc_q + 8'd1;
        en_d = 1'b0;
        if (apply) begin
            pc_d = 8'd0;
        end else if (pc_q >= presc_q) begin
            pc_d = 8'd0;
            en_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= 8'd0;
            en_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            en_q <= en_d;
        end
    end

`ifdef BTCFG_TIMEOUT_EN
    logic [9:0] tcnt_q, tcnt_d;

    always_comb begin
        tcnt_d = tcnt_q;
        if (state_q != ST_WAIT) begin
            tcnt_d = 10'd0;
        end else if (en_q) begin
            tcnt_d = tcnt_q + 10'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tcnt_q <= 10'd0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign tmo = (state_q == ST_WAIT) && en_q && (tcnt_q == TIMEOUT_TQ - 10'd1);
`else
    assign tmo = 1'b0;
`endif

    assign Prescale_EN = en_q;
    assign tseg1       = tseg1_q;
    assign tseg2       = tseg2_q;
    assign sjw         = sjw_q;
    assign cfg_busy    = (state_q != ST_IDLE);
    assign cfg_done    = (state_q == ST_APPLY) || (state_q == ST_REJECT);
    assign cfg_err     = err_q;
    assign cfg_ovr     = cfg_wr && cfg_busy;
    assign cfgst       = state_q;

endmodule

// File: tb/tb_bittime_cfgctrl.sv
// Randomised bench for bittime_cfgctrl against a request-lifecycle reference model.
module tb_bittime_cfgctrl;

    localparam int DEF_P  = 1;
    localparam int DEF_T1 = 7;
    localparam int DEF_T2 = 3;
    localparam int DEF_S  = 1;
    localparam int TMO    = 1023;

    logic       clock = 1'b0;
    logic       reset;
    logic       cfg_wr;
    logic [7:0] cfg_presc;
    logic [3:0] cfg_tseg1;
    logic [2:0] cfg_tseg2;
    logic [1:0] cfg_sjw;
    logic       busidle;
    logic       sendpoint;
    logic       Prescale_EN;
    logic [3:0] tseg1;
    logic [2:0] tseg2;
    logic [1:0] sjw;
    logic       cfg_busy;
    logic       cfg_done;
    logic [1:0] cfg_err;
    logic       cfg_ovr;
    logic [2:0] cfgst;

    always #5 clock = ~clock;

    bittime_cfgctrl dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_wr      (cfg_wr),
        .cfg_presc   (cfg_presc),
        .cfg_tseg1   (cfg_tseg1),
        .cfg_tseg2   (cfg_tseg2),
        .cfg_sjw     (cfg_sjw),
        .busidle     (busidle),
        .sendpoint   (sendpoint),
        .Prescale_EN (Prescale_EN),
        .tseg1       (tseg1),
        .tseg2       (tseg2),
        .sjw         (sjw),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .cfg_ovr     (cfg_ovr),
        .cfgst       (cfgst)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: active set, clocks since the prescaler last restarted, and one request.
    int m_presc, m_t1, m_t2, m_sjw, m_k, m_err;
    bit req, matched, rejecting;
    int age, tq;
    int q_presc, q_t1, q_t2, q_sjw;

    function automatic int model_state();
        if (!req)            return 0;
        else if (age == 1)   return 1;
        else if (matched)    return 3;
        else if (rejecting)  return 4;
        else                 return 2;
    endfunction

    task automatic model_reset();
        m_presc = DEF_P; m_t1 = DEF_T1; m_t2 = DEF_T2; m_sjw = DEF_S;
        m_k = 0; m_err = 0;
        req = 0; matched = 0; rejecting = 0; age = 0; tq = 0;
    endtask

    task automatic do_cycle(input bit wr, input int pr, input int t1, input int t2,
                            input int sj, input bit bi, input bit sp);
        int  st;
        bit  en_e;
        bit  applied;
        cfg_wr    = wr;
        cfg_presc = pr[7:0];
        cfg_tseg1 = t1[3:0];
        cfg_tseg2 = t2[2:0];
        cfg_sjw   = sj[1:0];
        busidle   = bi;
        sendpoint = sp;
        #1;
        en_e = (m_k >= 1) && ((m_k % (m_presc + 1)) == 0);
        st   = model_state();
        check_eq("prescale_en", Prescale_EN, en_e);
        check_eq("tseg1", tseg1, m_t1);
        check_eq("tseg2", tseg2, m_t2);
        check_eq("sjw", sjw, m_sjw);
        check_eq("cfg_busy", cfg_busy, req);
        check_eq("cfg_done", cfg_done, (st == 3 || st == 4));
        check_eq("cfg_err", cfg_err, m_err);
        check_eq("cfg_ovr", cfg_ovr, (wr && req));
        check_eq("cfgst", cfgst, st);
        applied = 0;
        case (st)
            0: if (wr) begin
                req = 1; age = 1; matched = 0; rejecting = 0; tq = 0; m_err = 0;
                q_presc = pr; q_t1 = t1; q_t2 = t2; q_sjw = sj;
            end
            1: begin
                age = 2;
                if (!(q_t2 >= 1 && q_sjw <= q_t2 && q_t1 >= q_t2)) begin
                    rejecting = 1; m_err = 1;
                end
            end
            2: begin
                if (en_e && sp && bi) begin
                    matched = 1;
                end
`ifdef BTCFG_TIMEOUT_EN
                else if (en_e) begin
                    tq++;
                    if (tq == TMO) begin
                        rejecting = 1; m_err = 2;
                    end
                end
`endif
            end
            3: begin
                m_presc = q_presc; m_t1 = q_t1; m_t2 = q_t2; m_sjw = q_sjw;
                m_err = 0; req = 0; applied = 1;
            end
            default: req = 0;
        endcase
        m_k = applied ? 0 : m_k + 1;
        @(negedge clock);
    endtask

    task automatic check_reset_values();
        check_eq("rst_en", Prescale_EN, 0);
        check_eq("rst_tseg1", tseg1, DEF_T1);
        check_eq("rst_tseg2", tseg2, DEF_T2);
        check_eq("rst_sjw", sjw, DEF_S);
        check_eq("rst_busy", cfg_busy, 0);
        check_eq("rst_done", cfg_done, 0);
        check_eq("rst_err", cfg_err, 0);
        check_eq("rst_ovr", cfg_ovr, 0);
        check_eq("rst_cfgst", cfgst, 0);
    endtask

    // Called at a falling edge; asserts reset asynchronously mid-phase.
    task automatic do_reset();
        cfg_wr = 1'b0;
        #3 reset = 1'b1;
        #1 check_reset_values();
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int bmode;
        int n_rst;
        bit bi, sp, wr;
        int pr, t1, t2, sj;
        reset = 1'b1; cfg_wr = 1'b0; cfg_presc = '0; cfg_tseg1 = '0; cfg_tseg2 = '0;
        cfg_sjw = '0; busidle = 1'b0; sendpoint = 1'b0;
        bmode = 1; n_rst = 0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        #1 check_reset_values();
        reset = 1'b0;

        // default rate after release
        repeat (8) do_cycle(0, 0, 0, 0, 0, 1, 0);
        // legal update at an idle boundary
        do_cycle(1, 4, 5, 2, 1, 1, 1);
        repeat (30) do_cycle(0, 0, 0, 0, 0, 1, 1);
        // illegal: tseg1 < tseg2
        do_cycle(1, 3, 2, 3, 1, 1, 1);
        repeat (12) do_cycle(0, 0, 0, 0, 0, 1, 1);
        // bus busy for more than 50 quanta, then idle
        do_cycle(1, 2, 9, 3, 2, 0, 1);
        repeat (270) do_cycle(0, 0, 0, 0, 0, 0, 1);
        repeat (20) do_cycle(0, 0, 0, 0, 0, 1, 1);
        // overrun while waiting
        do_cycle(1, 0, 6, 2, 2, 0, 1);
        repeat (5) do_cycle(0, 0, 0, 0, 0, 0, 1);
        do_cycle(1, 7, 15, 7, 3, 0, 1);
        repeat (20) do_cycle(0, 0, 0, 0, 0, 1, 1);

        for (int c = 0; c < 6000; c++) begin
            if (c % 150 == 0) bmode = $urandom_range(0, 2);
            bi = (bmode == 0) ? 1'b0 : (bmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            sp = ($urandom_range(0, 2) == 0);
            wr = ($urandom_range(0, 24) == 0);
            pr = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 4);
            t1 = $urandom_range(0, 15);
            t2 = $urandom_range(0, 7);
            sj = $urandom_range(0, 3);
            if (model_state() == 2 && n_rst < 6 && $urandom_range(0, 60) == 0) begin
                n_rst++;
                do_reset();
            end else begin
                do_cycle(wr, pr, t1, t2, sj, bi, sp);
            end
        end

`ifdef BTCFG_TIMEOUT_EN
        for (int c = 0; c < 5000 && req; c++) do_cycle(0, 0, 0, 0, 0, 1, 1);
        check_eq("drain_bound", req, 0);
        do_cycle(1, 1, 6, 2, 1, 0, 1);
        repeat (2 * TMO + 40) do_cycle(0, 0, 0, 0, 0, 0, 1);
        check_eq("timeout_err", cfg_err, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
